// File: rtl/sap1_controller_if.sv
// SAP-1 controller <-> datapath bundle: IR opcode in, ring state and
// register load/enable strobes out.
interface sap1_controller_if #(
    parameter int OPCODE_W = 4,
    parameter int T_STATES = 6
) ();
    logic [OPCODE_W-1:0] opcode;
    logic [T_STATES-1:0] t_state;
    logic cp, ep, lm, ce, li, ei;
    logic la, ea, su, eu, lb, lo;
    logic cycle_end;
    logic halt;

    modport master (
        input  opcode,
        output t_state,
        output cp, ep, lm, ce, li, ei,
        output la, ea, su, eu, lb, lo,
        output cycle_end, halt
    );

    modport slave (
        output opcode,
        input  t_state,
        input  cp, ep, lm, ce, li, ei,
        input  la, ea, su, eu, lb, lo,
        input  cycle_end, halt
    );
endinterface

// File: rtl/sap1_controller.sv
// SAP-1 control sequencer: one-hot T1..T6 ring plus opcode decode.
// Define SAP1_VAR_CYCLE_EN to end each instruction after its last useful T-state.
module sap1_controller #(
    parameter int OPCODE_W = 4,
    parameter int T_STATES = 6
) (
    input logic clk_i,
    input logic rst_i,
    sap1_controller_if.master ctl
);
    localparam logic [OPCODE_W-1:0] OP_LDA = OPCODE_W'(4'b0000);
    localparam logic [OPCODE_W-1:0] OP_ADD = OPCODE_W'(4'b0001);
    localparam logic [OPCODE_W-1:0] OP_SUB = OPCODE_W'(4'b0010);
    localparam logic [OPCODE_W-1:0] OP_OUT = OPCODE_W'(4'b1110);
    localparam logic [OPCODE_W-1:0] OP_HLT = OPCODE_W'(4'b1111);
    localparam logic [T_STATES-1:0] T1 = T_STATES'(1);

    logic [T_STATES-1:0] t_q, t_d, t_rot;
    logic halt_q, halt_d;
    logic is_lda, is_add, is_sub, is_out, is_hlt, is_nop;
    logic last;

    assign t_rot = {t_q[T_STATES-2:0], t_q[T_STATES-1]};

    always_comb begin
        is_lda = 1'b0;
        is_add = 1'b0;
        is_sub = 1'b0;
        is_out = 1'b0;
        is_hlt = 1'b0;
        is_nop = 1'b0;
        unique case (ctl.opcode)
            OP_LDA:  is_lda = 1'b1;
            OP_ADD:  is_add = 1'b1;
            OP_SUB:  is_sub = 1'b1;
            OP_OUT:  is_out = 1'b1;
            OP_HLT:  is_hlt = 1'b1;
            default: is_nop = 1'b1;
        endcase
    end

    // last: final T-state of the current instruction, ungated by reset
`ifdef SAP1_VAR_CYCLE_EN
    assign last = (is_lda & t_q[4])
                | (is_out & t_q[3])
                | (is_nop & t_q[2])
                | ((is_add | is_sub) & t_q[5])
                | (is_hlt & t_q[3]);
`else
    assign last = t_q[5] | (is_hlt & t_q[3]);
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            t_q    <= T1;
            halt_q <= 1'b0;
        end else begin
            t_q    <= t_d;
            halt_q <= halt_d;
        end
    end

    // HLT still steps into T5, then the ring freezes there
    always_comb begin
        t_d    = t_q;
        halt_d = halt_q;
        if (!halt_q) begin
            if (is_hlt && t_q[3]) begin
                t_d    = t_rot;
                halt_d = 1'b1;
            end else if (last) begin
                t_d = T1;
            end else begin
                t_d = t_rot;
            end
        end
    end

    always_comb begin
        ctl.cp        = 1'b0;
        ctl.ep        = 1'b0;
        ctl.lm        = 1'b0;
        ctl.ce        = 1'b0;
        ctl.li        = 1'b0;
        ctl.ei        = 1'b0;
        ctl.la        = 1'b0;
        ctl.ea        = 1'b0;
        ctl.su        = 1'b0;
        ctl.eu        = 1'b0;
        ctl.lb        = 1'b0;
        ctl.lo        = 1'b0;
        ctl.cycle_end = 1'b0;
        if (!rst_i && !halt_q) begin
            ctl.cycle_end = last;
            unique case (1'b1)
                t_q[0]: begin
                    ctl.ep = 1'b1;
                    ctl.lm = 1'b1;
                end
                t_q[1]: ctl.cp = 1'b1;
                t_q[2]: begin
                    ctl.ce = 1'b1;
                    ctl.li = 1'b1;
                end
                t_q[3]: begin
                    ctl.ei = is_lda | is_add | is_sub;
                    ctl.lm = is_lda | is_add | is_sub;
                    ctl.ea = is_out;
                    ctl.lo = is_out;
                end
                t_q[4]: begin
                    ctl.ce = is_lda | is_add | is_sub;
                    ctl.la = is_lda;
                    ctl.lb = is_add | is_sub;
                end
                t_q[5]: begin
                    ctl.eu = is_add | is_sub;
                    ctl.la = is_add | is_sub;
                    ctl.su = is_sub;
                end
                default: ;
            endcase
        end
    end

    assign ctl.t_state = t_q;
    assign ctl.halt    = halt_q;
endmodule

// File: tb/tb_sap1_controller.sv
// Scoreboard bench for sap1_controller: expected control words are queued
// as each T-state is driven and popped when the outputs are sampled.
module tb_sap1_controller;
    localparam logic [11:0] W_CP = 12'b1000_0000_0000;
    localparam logic [11:0] W_EP = 12'b0100_0000_0000;
    localparam logic [11:0] W_LM = 12'b0010_0000_0000;
    localparam logic [11:0] W_CE = 12'b0001_0000_0000;
    localparam logic [11:0] W_LI = 12'b0000_1000_0000;
    localparam logic [11:0] W_EI = 12'b0000_0100_0000;
    localparam logic [11:0] W_LA = 12'b0000_0010_0000;
    localparam logic [11:0] W_EA = 12'b0000_0001_0000;
    localparam logic [11:0] W_SU = 12'b0000_0000_1000;
    localparam logic [11:0] W_EU = 12'b0000_0000_0100;
    localparam logic [11:0] W_LB = 12'b0000_0000_0010;
    localparam logic [11:0] W_LO = 12'b0000_0000_0001;

`ifdef SAP1_VAR_CYCLE_EN
    localparam int LEN_LDA = 5;
    localparam int LEN_OUT = 4;
    localparam int LEN_NOP = 3;
`else
    localparam int LEN_LDA = 6;
    localparam int LEN_OUT = 6;
    localparam int LEN_NOP = 6;
`endif

    typedef struct {
        logic [5:0]  t;
        logic [11:0] w;
        logic        ce;
        logic        h;
    } sb_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_pass = 0;
    int   n_chk  = 0;
    int   m_t    = 1;
    bit   m_halt = 1'b0;
    sb_t  sbq[$];

    always #5 clk = ~clk;

    sap1_controller_if ctl ();

    sap1_controller dut (
        .clk_i (clk),
        .rst_i (rst),
        .ctl   (ctl)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h (t=%0t)",
                      tag, got, exp, $time);
    endtask

    function automatic logic [11:0] exp_word(input logic [3:0] op,
                                             input int t);
        logic mem;
        mem = (op == 4'b0000) || (op == 4'b0001) || (op == 4'b0010);
        case (t)
            1: return W_EP | W_LM;
            2: return W_CP;
            3: return W_CE | W_LI;
            4: if (mem) return W_EI | W_LM;
               else if (op == 4'b1110) return W_EA | W_LO;
            5: if (op == 4'b0000) return W_CE | W_LA;
               else if (op == 4'b0001 || op == 4'b0010) return W_CE | W_LB;
            6: if (op == 4'b0001) return W_EU | W_LA;
               else if (op == 4'b0010) return W_SU | W_EU | W_LA;
            default: ;
        endcase
        return 12'h000;
    endfunction

    function automatic bit exp_end(input logic [3:0] op, input int t);
`ifdef SAP1_VAR_CYCLE_EN
        case (op)
            4'b0000: return t == 5;
            4'b0001, 4'b0010: return t == 6;
            4'b1110, 4'b1111: return t == 4;
            default: return t == 3;
        endcase
`else
        return (t == 6) || (op == 4'b1111 && t == 4);
`endif
    endfunction

    task automatic step(input logic [3:0] op, input logic r);
        sb_t e;
        sb_t g;
        logic [11:0] w;
        ctl.opcode = op;
        rst = r;
        e.t  = 6'(1 << (m_t - 1));
        e.w  = (r || m_halt) ? 12'h000 : exp_word(op, m_t);
        e.ce = (r || m_halt) ? 1'b0 : exp_end(op, m_t);
        e.h  = m_halt;
        sbq.push_back(e);
        #2;
        g = sbq.pop_front();
        w = {ctl.cp, ctl.ep, ctl.lm, ctl.ce, ctl.li, ctl.ei,
             ctl.la, ctl.ea, ctl.su, ctl.eu, ctl.lb, ctl.lo};
        chk("t_state", 32'(ctl.t_state), 32'(g.t));
        chk("ctrl", 32'(w), 32'(g.w));
        chk("cycle_end", 32'(ctl.cycle_end), 32'(g.ce));
        chk("halt", 32'(ctl.halt), 32'(g.h));
        chk("bus_excl", 32'($countones({ctl.ep, ctl.ce, ctl.ei,
                                         ctl.ea, ctl.eu}) <= 1), 32'd1);
        chk("su_eu", 32'(!ctl.su || ctl.eu), 32'd1);
        @(posedge clk);
        #1;
        if (r) begin
            m_t    = 1;
            m_halt = 1'b0;
        end else if (m_halt) begin
            m_t = m_t;
        end else if (op == 4'b1111 && m_t == 4) begin
            m_t    = 5;
            m_halt = 1'b1;
        end else if (exp_end(op, m_t)) begin
            m_t = 1;
        end else begin
            m_t = (m_t % 6) + 1;
        end
    endtask

    task automatic run(input string tag, input logic [3:0] op,
                       input int len);
        int n;
        n = 0;
        do begin
            step(op, 1'b0);
            n++;
        end while (m_t != 1 && n < 8);
        chk({tag, "_len"}, 32'(n), 32'(len));
        chk({tag, "_t1"}, 32'(ctl.t_state), 32'h01);
    endtask

    initial begin
        ctl.opcode = 4'b0000;
        rst = 1'b1;
        @(posedge clk);
        #1;
        m_t = 1;
        m_halt = 1'b0;
        step(4'b0000, 1'b1);

        run("add", 4'b0001, 6);
        run("sub", 4'b0010, 6);
        run("lda", 4'b0000, LEN_LDA);
        run("out", 4'b1110, LEN_OUT);
        run("nop", 4'b0101, LEN_NOP);

        for (int i = 0; i < 4; i++) step(4'b0001, 1'b0);
        step(4'b0001, 1'b1);
        chk("midrst_t", 32'(ctl.t_state), 32'h01);

        for (int i = 0; i < 4; i++) step(4'b1111, 1'b0);
        chk("hlt_flag", 32'(ctl.halt), 32'd1);
        for (int i = 0; i < 10; i++) step(4'b1111, 1'b0);
        chk("hlt_frozen", 32'(ctl.t_state), 32'h10);
        step(4'b1111, 1'b1);
        chk("hlt_clr", 32'(ctl.halt), 32'd0);
        step(4'b0000, 1'b0);

        if (sbq.size() != 0) chk("sb_empty", 32'(sbq.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running want finished");
        $fatal(1);
    end
endmodule

// File: doc/sap1_controller.md
Name: sap1_controller

Overview:
- Control sequencer for the SAP-1 8-bit bus datapath: PC, MAR, RAM, IR, accumulator A, register B, ALU and output register.
- A one-hot ring counter steps T1..T6 each clock. The opcode from the IR is decoded into the per-T-state control word that drives the load/enable pins of every datapath register, including register B's load.
- Sits beside the IR and drives all datapath control lines. There is one controller per SAP-1 core.

Parameters:
- OPCODE_W, 4, opcode width taken from the IR upper nibble.
- T_STATES, 6, ring counter length; fixed at 6, any other value is unsupported.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  synchronous, active-high reset.
- opcode  input  OPCODE_W  IR upper nibble; valid from T4 through T6.
- t_state  output  T_STATES  one-hot ring state; bit0 = T1.
- cp  output  1  PC increment.
- ep  output  1  PC drives bus.
- lm  output  1  MAR load.
- ce  output  1  RAM drives bus (active-high in this block).
- li  output  1  IR load.
- ei  output  1  IR low nibble drives bus.
- la  output  1  A load.
- ea  output  1  A drives bus.
- su  output  1  ALU subtract select.
- eu  output  1  ALU drives bus.
- lb  output  1  B load.
- lo  output  1  output register load.
- cycle_end  output  1  high during the final T-state of the current instruction.
- halt  output  1  high once HLT has executed; sticky until rst.

Behaviour:
- Reset (rst=1 at a rising edge):
  - t_state <= 6'b000001 and halt <= 0.
  - While rst is high, all control outputs and cycle_end are forced to 0 combinationally.
- Ring counter:
  - Each rising edge with rst=0 and halt=0 rotates left: T1->T2->...->T6->T1.
  - Exactly one t_state bit is high at all times.
- Control outputs are combinational from t_state and opcode. There is no output register; latency is 0 within a T-state.
- Fetch cycle, identical for all opcodes:
  - T1: ep, lm.
  - T2: cp.
  - T3: ce, li.
- Execute cycle:
  - LDA 0000: T4 ei, lm; T5 ce, la; T6 none.
  - ADD 0001: T4 ei, lm; T5 ce, lb; T6 eu, la.
  - SUB 0010: T4 ei, lm; T5 ce, lb; T6 su, eu, la.
  - OUT 1110: T4 ea, lo; T5 none; T6 none.
  - HLT 1111: T4 all control outputs 0, and halt <= 1 at the end of T4.
  - Any other opcode is a NOP: T4–T6 all control outputs 0.
- Exclusivity:
  - At most one bus driver (ep, ce, ei, ea, eu) is high in any T-state.
  - su is asserted only together with eu.
- cycle_end is high in T6 (all opcodes, macro off). It is also high in T4 for HLT.
- Halted state:
  - t_state freezes at T5 after the HLT edge.
  - All control outputs and cycle_end are 0; halt stays 1.
  - Only rst clears the halted state.
- rst mid-instruction: on the next edge the controller returns to T1 with halt=0, regardless of state or opcode.
- Opcode changes during T4–T6 are followed combinationally. The IR is loaded only in T3, so opcode is stable during execute.

Optional Feature:
SAP1_VAR_CYCLE_EN
- Defined: variable-length machine cycle. After the final useful T-state the ring returns to T1 instead of continuing to T6.
  - LDA: T5->T1 (5 states).
  - OUT: T4->T1 (4 states).
  - NOP: T3->T1 (3 states).
  - ADD/SUB: unchanged (6 states).
  - cycle_end is asserted in that final state.
- Undefined: fixed 6-state cycle for every instruction. cycle_end is asserted only in T6 (T4 for HLT).

Test Plan:
- rst=1 for 2 edges, then 0 -> t_state=000001 and halt=0; during reset all control outputs are 0; first cycle after release: ep=1, lm=1.
- opcode=0001 (ADD) over six clocks -> control words T1 {ep,lm}, T2 {cp}, T3 {ce,li}, T4 {ei,lm}, T5 {ce,lb}, T6 {eu,la}; cycle_end=1 only in T6; t_state returns to 000001.
- opcode=0010 (SUB) -> T6 asserts su=1, eu=1, la=1; all other T-states match ADD.
- opcode=0000 (LDA), then 1110 (OUT) -> LDA T5 {ce,la}; OUT T4 {ea,lo}. With SAP1_VAR_CYCLE_EN, t_state reaches 000001 after 5 and 4 clocks respectively; without it, after 6.
- opcode=1111 at T4 -> halt=1 from the next edge; t_state frozen at 010000 for 10 clocks with all control outputs 0; rst=1 for one edge -> halt=0 and t_state=000001.
- Assert rst during T5 of an ADD -> next edge t_state=000001; lb is never asserted after rst rises; every cycle checked for at most one bus-driver enable high.
